// File: rtl/fila_pedidos_pkg.sv
// fila_pedidos_pkg
// Shared types and constants for the elevator call-request queue.
//   estado_t   : write-FSM state encoding (also exported on db_estado)
//   entry_t    : one queue entry {eh_origem, floor}
//   make_entry : builds an entry from a flag and a zero-extended floor
// Floors are kept at FLOOR_W_MAX bits inside entries so one struct serves
// every FLOOR_W; the unused upper bits are always zero and trim away.
package fila_pedidos_pkg;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_FLOOR_W = 2;
  localparam int FLOOR_W_MAX = 8;

  typedef enum logic [1:0] {
    OCIOSO        = 2'b00,
    GRAVA_ORIGEM  = 2'b01,
    GRAVA_DESTINO = 2'b10,
    RECUSA        = 2'b11
  } estado_t;

  typedef struct packed {
    logic                   eh_origem;
    logic [FLOOR_W_MAX-1:0] floor;
  } entry_t;

  function automatic entry_t make_entry(input logic eh_origem,
                                        input logic [FLOOR_W_MAX-1:0] floor);
    entry_t e;
    e.eh_origem = eh_origem;
    e.floor     = floor;
    return e;
  endfunction

endpackage

// File: rtl/fila_pedidos_if.sv
// fila_pedidos_if
// Request / service handshake between the call panel, the movement unit
// and the queue.
//   novoPedido, origem, destino : new call request (pulse + floors)
//   pedidoRecusado              : pulse when a request was dropped
//   shift                       : pop the head entry
//   temDestino, andarDestino, eh_origem, sobe, chegouDestino : head view
// Modports: master drives requests/shift, slave is the queue.
interface fila_pedidos_if
  import fila_pedidos_pkg::*;
#(
  parameter int FLOOR_W = DEF_FLOOR_W
) ();

  logic               novoPedido;
  logic [FLOOR_W-1:0] origem;
  logic [FLOOR_W-1:0] destino;
  logic               pedidoRecusado;
  logic               shift;
  logic               temDestino;
  logic [FLOOR_W-1:0] andarDestino;
  logic               eh_origem;
  logic               sobe;
  logic               chegouDestino;

  modport master (
    output novoPedido, origem, destino, shift,
    input  pedidoRecusado, temDestino, andarDestino, eh_origem, sobe,
           chegouDestino
  );

  modport slave (
    input  novoPedido, origem, destino, shift,
    output pedidoRecusado, temDestino, andarDestino, eh_origem, sobe,
           chegouDestino
  );

endinterface

// File: rtl/fila_pedidos_fifo.sv
// fifo_pedidos
// Circular entry storage for fila_pedidos.
//   clock, reset      : system clock, async active-high reset
//   clear             : synchronous flush, wins over push and pop
//   push, push_entry  : write one entry at the tail
//   pop               : drop the head entry (ignored when empty)
//   head              : entry at the read pointer
//   ocupacao          : number of stored entries (0..DEPTH)
//   rd_ptr, wr_ptr    : pointer taps, present only with FILA_PEDIDOS_DEDUP_EN
// Pointers wrap modulo DEPTH (power of two); full vs empty is told apart by
// ocupacao because equal pointers mean either.
module fifo_pedidos
  import fila_pedidos_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] ocupacao
`ifdef FILA_PEDIDOS_DEDUP_EN
  ,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH)-1:0] wr_ptr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic             pop_ok;
  logic             push_ok;

  // A pop on an empty queue is dropped; a push into a full queue is only
  // allowed when a pop frees a slot in the same cycle.
  assign pop_ok  = pop && (ocupacao != '0);
  assign push_ok = push && ((ocupacao != OCC_W'(DEPTH)) || pop_ok);

  // Storage carries no reset; stale slots are never visible because
  // temDestino gates every head-derived output.
  always_ff @(posedge clock) begin
    if (push_ok && !clear) begin
      mem[wr_q] <= push_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q     <= '0;
      wr_q     <= '0;
      ocupacao <= '0;
    end else if (clear) begin
      rd_q     <= '0;
      wr_q     <= '0;
      ocupacao <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_W'(1);
      if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   ocupacao <= ocupacao + OCC_W'(1);
        2'b01:   ocupacao <= ocupacao - OCC_W'(1);
        default: ocupacao <= ocupacao;
      endcase
    end
  end

  assign head = mem[rd_q];

`ifdef FILA_PEDIDOS_DEDUP_EN
  assign rd_ptr = rd_q;
  assign wr_ptr = wr_q;
`endif

endmodule

// File: rtl/fila_pedidos.sv
// fila_pedidos
// Elevator call-request queue. Each accepted request becomes two entries,
// the pickup floor (eh_origem=1) followed by the drop-off floor.
//   clock, reset   : system clock, async active-high reset
//   clearFila      : synchronous flush from the movement unit
//   andarAtual     : current elevator floor
//   bus (slave)    : request handshake and head view, see fila_pedidos_if
//   cheia          : fewer than two free entries
//   ocupacao       : stored entries
//   db_estado      : write-FSM state
// Build option: FILA_PEDIDOS_DEDUP_EN rejects a request equal to the last
// accepted pair while that pair's pickup entry has not been popped yet.
module fila_pedidos
  import fila_pedidos_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int FLOOR_W = DEF_FLOOR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clearFila,
  input  logic [FLOOR_W-1:0]     andarAtual,
  fila_pedidos_if.slave          bus,
  output logic                   cheia,
  output logic [$clog2(DEPTH):0] ocupacao,
  output logic [1:0]             db_estado
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  estado_t                estado;
  logic [FLOOR_W-1:0]     origem_q;
  logic [FLOOR_W-1:0]     destino_q;
  logic                   push;
  entry_t                 push_entry;
  entry_t                 head;
  logic                   pop_ok;
  logic                   duplicado;
  logic                   invalido;
  logic                   tem_destino;
  logic [FLOOR_W_MAX-1:0] atual_ext;

  // Two free slots must exist before accepting, so the destination write
  // can never find the queue full.
  assign cheia = ocupacao > OCC_W'(DEPTH - 2);

  assign pop_ok = bus.shift && (ocupacao != '0) && !clearFila;

`ifdef FILA_PEDIDOS_DEDUP_EN
  logic               dup_valid;
  logic [FLOOR_W-1:0] dup_origem;
  logic [FLOOR_W-1:0] dup_destino;
  logic [PTR_W-1:0]   dup_idx;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  assign duplicado = dup_valid && (bus.origem == dup_origem)
                     && (bus.destino == dup_destino);

  // The last accepted pair stays armed until the slot holding its pickup
  // entry is popped; a new pickup write re-arms with its own slot index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dup_valid   <= 1'b0;
      dup_origem  <= '0;
      dup_destino <= '0;
      dup_idx     <= '0;
    end else if (clearFila) begin
      dup_valid <= 1'b0;
    end else begin
      if (pop_ok && dup_valid && (rd_ptr == dup_idx)) begin
        dup_valid <= 1'b0;
      end
      if (estado == GRAVA_ORIGEM) begin
        dup_valid   <= 1'b1;
        dup_origem  <= origem_q;
        dup_destino <= destino_q;
        dup_idx     <= wr_ptr;
      end
    end
  end
`else
  assign duplicado = 1'b0;
`endif

  assign invalido = (bus.origem == bus.destino) || cheia || duplicado;

  // Write FSM: latch a request in OCIOSO, then write pickup and drop-off
  // entries in consecutive cycles, or spend one cycle signalling refusal.
  // Requests arriving outside OCIOSO are ignored silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      origem_q  <= '0;
      destino_q <= '0;
    end else if (clearFila) begin
      estado    <= OCIOSO;
      origem_q  <= '0;
      destino_q <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (bus.novoPedido) begin
            origem_q  <= bus.origem;
            destino_q <= bus.destino;
            estado    <= invalido ? RECUSA : GRAVA_ORIGEM;
          end
        end
        GRAVA_ORIGEM:  estado <= GRAVA_DESTINO;
        GRAVA_DESTINO: estado <= OCIOSO;
        RECUSA:        estado <= OCIOSO;
        default:       estado <= OCIOSO;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    push_entry = make_entry(1'b1, FLOOR_W_MAX'(origem_q));
    case (estado)
      GRAVA_ORIGEM: push = 1'b1;
      GRAVA_DESTINO: begin
        push       = 1'b1;
        push_entry = make_entry(1'b0, FLOOR_W_MAX'(destino_q));
      end
      default: push = 1'b0;
    endcase
  end

  fifo_pedidos #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (clearFila),
    .push       (push),
    .push_entry (push_entry),
    .pop        (bus.shift),
    .head       (head),
    .ocupacao   (ocupacao)
`ifdef FILA_PEDIDOS_DEDUP_EN
    ,
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr)
`endif
  );

  // Comparisons run at full entry width; the zero upper bits of both
  // operands make this identical to a FLOOR_W-bit compare.
  assign atual_ext   = FLOOR_W_MAX'(andarAtual);
  assign tem_destino = (ocupacao != '0);

  assign bus.temDestino     = tem_destino;
  assign bus.andarDestino   = head.floor[FLOOR_W-1:0];
  assign bus.eh_origem      = head.eh_origem;
  assign bus.sobe           = tem_destino && (head.floor > atual_ext);
  assign bus.chegouDestino  = tem_destino && (head.floor == atual_ext);
  assign bus.pedidoRecusado = (estado == RECUSA);
  assign db_estado          = estado;

endmodule

// File: tb/tb_fila_pedidos.sv
// tb_fila_pedidos
// Directed bench for fila_pedidos (DEPTH=8, FLOOR_W=2). Inputs change just
// after the falling edge; outputs are sampled 1 time unit after it.
// Build option: FILA_PEDIDOS_DEDUP_EN selects the duplicate-request steps.
module tb_fila_pedidos;

  logic       clock;
  logic       reset;
  logic       clearFila;
  logic [1:0] andarAtual;
  logic       cheia;
  logic [3:0] ocupacao;
  logic [1:0] db_estado;
  int         checks;
  int         errors;

  fila_pedidos_if #(.FLOOR_W(2)) bus ();

  fila_pedidos #(
    .DEPTH   (8),
    .FLOOR_W (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clearFila  (clearFila),
    .andarAtual (andarAtual),
    .bus        (bus),
    .cheia      (cheia),
    .ocupacao   (ocupacao),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs across a rising edge, then release pulses.
  task automatic applyStimulus(input logic novo, input logic [1:0] o,
                               input logic [1:0] d, input logic sh,
                               input logic clr);
    bus.novoPedido = novo;
    bus.origem     = o;
    bus.destino    = d;
    bus.shift      = sh;
    clearFila      = clr;
    @(negedge clock);
    #1;
    bus.novoPedido = 1'b0;
    bus.shift      = 1'b0;
    clearFila      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    clearFila      = 1'b0;
    andarAtual     = 2'd0;
    bus.novoPedido = 1'b0;
    bus.origem     = 2'd0;
    bus.destino    = 2'd0;
    bus.shift      = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;

    checkOutput("rst_tem",      bus.temDestino, 0);
    checkOutput("rst_chegou",   bus.chegouDestino, 0);
    checkOutput("rst_sobe",     bus.sobe, 0);
    checkOutput("rst_recusado", bus.pedidoRecusado, 0);
    checkOutput("rst_cheia",    cheia, 0);
    checkOutput("rst_ocup",     ocupacao, 0);
    checkOutput("rst_estado",   db_estado, 0);

    // Request 1 -> 3 from floor 0
    applyStimulus(1'b1, 2'd1, 2'd3, 1'b0, 1'b0);
    checkOutput("r1_estado_go", db_estado, 1);
    checkOutput("r1_tem_early", bus.temDestino, 0);
    idle(1);
    checkOutput("r1_tem",       bus.temDestino, 1);
    checkOutput("r1_andar",     bus.andarDestino, 1);
    checkOutput("r1_eh_origem", bus.eh_origem, 1);
    checkOutput("r1_sobe",      bus.sobe, 1);
    checkOutput("r1_ocup1",     ocupacao, 1);
    idle(1);
    checkOutput("r1_ocup2",     ocupacao, 2);
    checkOutput("r1_estado_id", db_estado, 0);

    // Serve it
    andarAtual = 2'd1;
    #1;
    checkOutput("pop_chegou",  bus.chegouDestino, 1);
    checkOutput("pop_sobe0",   bus.sobe, 0);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("pop_eh",      bus.eh_origem, 0);
    checkOutput("pop_andar",   bus.andarDestino, 3);
    checkOutput("pop_sobe1",   bus.sobe, 1);
    checkOutput("pop_ocup1",   ocupacao, 1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("pop_tem0",    bus.temDestino, 0);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("empty_shift", ocupacao, 0);
    andarAtual = 2'd0;

    // origem == destino is refused
    applyStimulus(1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
    checkOutput("inv_recusado", bus.pedidoRecusado, 1);
    checkOutput("inv_estado",   db_estado, 3);
    idle(1);
    checkOutput("inv_pulse",    bus.pedidoRecusado, 0);
    checkOutput("inv_ocup",     ocupacao, 0);

    // A request while busy is ignored without refusal
    applyStimulus(1'b1, 2'd0, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
    checkOutput("busy_estado",  db_estado, 2);
    checkOutput("busy_recus",   bus.pedidoRecusado, 0);
    idle(1);
    checkOutput("busy_recus2",  bus.pedidoRecusado, 0);
    checkOutput("busy_ocup",    ocupacao, 2);
    checkOutput("busy_head",    bus.andarDestino, 0);
    checkOutput("busy_eh",      bus.eh_origem, 1);
    checkOutput("busy_chegou",  bus.chegouDestino, 1);

    // Shift during GRAVA_DESTINO with ocupacao = 3
    applyStimulus(1'b1, 2'd3, 2'd2, 1'b0, 1'b0);
    idle(1);
    checkOutput("sim_ocup3",    ocupacao, 3);
    checkOutput("sim_estado",   db_estado, 2);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("sim_ocup",     ocupacao, 3);
    checkOutput("sim_head_eh",  bus.eh_origem, 0);
    checkOutput("sim_head_fl",  bus.andarDestino, 1);

    // Flush, then fill to capacity
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("clr_ocup",     ocupacao, 0);
    checkOutput("clr_tem",      bus.temDestino, 0);
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 2'd2, 2'd3, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    idle(2);
    checkOutput("fill_ocup6",   ocupacao, 6);
    checkOutput("fill_cheia0",  cheia, 0);
    applyStimulus(1'b1, 2'd0, 2'd3, 1'b0, 1'b0);
    idle(2);
    checkOutput("fill_ocup8",   ocupacao, 8);
    checkOutput("fill_cheia1",  cheia, 1);
    applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    checkOutput("full_recus",   bus.pedidoRecusado, 1);
    idle(1);
    checkOutput("full_ocup",    ocupacao, 8);
    checkOutput("full_head",    bus.andarDestino, 1);

    // Flush in GRAVA_ORIGEM drops the half-latched request
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd2, 2'd1, 1'b0, 1'b0);
    checkOutput("cg_estado1",   db_estado, 1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    checkOutput("cg_estado",    db_estado, 0);
    checkOutput("cg_ocup",      ocupacao, 0);
    checkOutput("cg_tem",       bus.temDestino, 0);
    idle(2);
    checkOutput("cg_ocup_late", ocupacao, 0);

    // Reset in GRAVA_ORIGEM
    applyStimulus(1'b1, 2'd1, 2'd3, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("rmid_estado",  db_estado, 0);
    checkOutput("rmid_ocup",    ocupacao, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);
    checkOutput("rmid_ocup2",   ocupacao, 0);
    checkOutput("rmid_tem",     bus.temDestino, 0);

    // Repeated request 0 -> 2
    applyStimulus(1'b1, 2'd0, 2'd2, 1'b0, 1'b0);
    idle(2);
    checkOutput("dup_first",    ocupacao, 2);
`ifdef FILA_PEDIDOS_DEDUP_EN
    applyStimulus(1'b1, 2'd0, 2'd2, 1'b0, 1'b0);
    checkOutput("dup_recus",    bus.pedidoRecusado, 1);
    idle(1);
    checkOutput("dup_ocup",     ocupacao, 2);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 2'd2, 1'b0, 1'b0);
    checkOutput("dup_again",    db_estado, 1);
    idle(2);
    checkOutput("dup_ocup3",    ocupacao, 3);
`else
    applyStimulus(1'b1, 2'd0, 2'd2, 1'b0, 1'b0);
    checkOutput("dup_accept",   db_estado, 1);
    checkOutput("dup_norecus",  bus.pedidoRecusado, 0);
    idle(2);
    checkOutput("dup_ocup4",    ocupacao, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fila_pedidos.md
FILA_PEDIDOS -- requirements
Module: fila_pedidos

Interface
REQ-001 Parameter DEPTH, default 8, queue capacity in entries, power of two, at least 4.
REQ-002 Parameter FLOOR_W, default 2, floor-number width.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 clearFila  input  1  synchronous queue clear, driven by the movement unit at initialisation.
REQ-006 novoPedido  input  1  one-cycle pulse; a call request is present on origem/destino.
REQ-007 origem  input  FLOOR_W  pickup floor.
REQ-008 destino  input  FLOOR_W  drop-off floor.
REQ-009 andarAtual  input  FLOOR_W  current elevator floor.
REQ-010 shift  input  1  pops the head entry; one pulse per served entry.
REQ-011 temDestino  output  1  queue not empty.
REQ-012 andarDestino  output  FLOOR_W  floor of the head entry.
REQ-013 eh_origem  output  1  head entry is a pickup (1) or a drop-off (0).
REQ-014 sobe  output  1  andarDestino greater than andarAtual.
REQ-015 chegouDestino  output  1  temDestino and andarDestino equal to andarAtual.
REQ-016 cheia  output  1  fewer than 2 free entries.
REQ-017 ocupacao  output  log2(DEPTH)+1  number of stored entries.
REQ-018 pedidoRecusado  output  1  one-cycle pulse; the request was dropped.
REQ-019 db_estado  output  2  current write-FSM state.

Function
REQ-020 Each entry holds {eh_origem, floor}; an accepted request pushes its origin entry (eh_origem=1) and then its destination entry (eh_origem=0), in consecutive cycles.
REQ-021 Write FSM states: OCIOSO(00), GRAVA_ORIGEM(01), GRAVA_DESTINO(10), RECUSA(11).
REQ-022 OCIOSO: on novoPedido, latch origem/destino; go to RECUSA if the request is invalid, else GRAVA_ORIGEM.
REQ-023 A request is invalid when origem == destino, or cheia is 1 in the sampling cycle.
REQ-024 GRAVA_ORIGEM writes the origin entry and goes to GRAVA_DESTINO; GRAVA_DESTINO writes the destination entry and goes to OCIOSO; RECUSA asserts pedidoRecusado and goes to OCIOSO.
REQ-025 Accept-to-visible latency: the origin entry is readable 2 cycles after the novoPedido edge.
REQ-026 novoPedido outside OCIOSO is ignored, with no pedidoRecusado pulse.
REQ-027 temDestino, andarDestino, eh_origem, sobe, chegouDestino and cheia are combinational from registered state and andarAtual only.
REQ-028 shift when the queue is empty is ignored: pointers and ocupacao are unchanged.
REQ-029 A push and a shift in the same cycle both take effect; ocupacao is unchanged.
REQ-030 Read and write pointers wrap modulo DEPTH; a full/empty distinction uses ocupacao, never pointer equality alone.
REQ-031 A 2-entry reservation check (REQ-023) guarantees that GRAVA_DESTINO never overflows.
REQ-032 clearFila zeroes the pointers and ocupacao, forces OCIOSO and discards any latched request; it has priority over novoPedido, a push and shift in the same cycle.

Reset
REQ-033 reset forces OCIOSO and zero pointers and ocupacao.
REQ-034 After reset: temDestino=0, chegouDestino=0, sobe=0, pedidoRecusado=0, cheia=0.
REQ-035 Storage contents need no reset; andarDestino and eh_origem are don't-care while temDestino=0.
REQ-036 A reset between GRAVA_ORIGEM and GRAVA_DESTINO discards the half-written request.

Configuration
REQ-037 The macro FILA_PEDIDOS_DEDUP_EN controls duplicate rejection.
REQ-038 With FILA_PEDIDOS_DEDUP_EN defined:
- a request whose (origem, destino) equals the last accepted pair is routed to RECUSA while that pair's origin entry is still unserved;
- the origin entry counts as unserved until the pop of that entry.
REQ-039 With FILA_PEDIDOS_DEDUP_EN undefined, duplicates are accepted and the last-pair registers do not exist.

Structure
REQ-040 The shared package fila_pedidos_pkg holds:
- the entry struct {eh_origem, floor};
- the FSM state enum with the encodings of REQ-021;
- default DEPTH and FLOOR_W constants.
REQ-041 One sub-module, fifo_pedidos, holds the storage array, pointers and ocupacao with push/pop/clear ports; fila_pedidos holds the FSM, validation and comparators.

Verification
REQ-042 After reset: novoPedido with origem=1, destino=3, andarAtual=0.
- 2 cycles later: temDestino=1, andarDestino=1, eh_origem=1, sobe=1.
- Final state: ocupacao=2.
REQ-043 Pop sequence on the REQ-042 queue:
- andarAtual=1: chegouDestino=1.
- shift: head is {0,3}, sobe=1.
- shift again: temDestino=0.
REQ-044 DEPTH=8: issue 3 valid requests so that ocupacao=6 and cheia=0.
- A 4th request is accepted: ocupacao=8, cheia=1.
- A 5th request: pedidoRecusado pulses and ocupacao stays 8.
REQ-045 Invalid and simultaneous events:
- origem=2, destino=2: pedidoRecusado=1, queue unchanged.
- A shift during GRAVA_DESTINO with ocupacao=3: ocupacao=3 afterwards.
REQ-046 clearFila asserted in GRAVA_ORIGEM: the next cycle shows OCIOSO, ocupacao=0 and temDestino=0, and the destination entry is never written.
REQ-047 FILA_PEDIDOS_DEDUP_EN defined: request 0 to 2 twice gives pedidoRecusado on the second; after one shift, the same request is accepted.
